// File: rtl/date_pkg.sv
// Shared constants, types and helpers for the date-to-day-of-year path.
package date_pkg;

    localparam int DOY_W      = 9;
    localparam int BCD_W      = 4;
    localparam int DOY_MAX    = 366;
    localparam int NUM_MONTHS = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
        S_ACCUM,
        S_CONVERT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] month;
        logic [3:0] day_tens;
        logic [3:0] day_ones;
        logic       leap;
    } date_req_t;

    localparam logic [4:0] MONTH_LEN [NUM_MONTHS] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // Zero for out-of-range months, so the caller's range check stays simple.
    function automatic logic [4:0] month_len(
        input logic [3:0] m,
        input logic       leap_eff
    );
        logic [4:0] len;
        len = 5'd0;
        if (m >= 4'd1 && m <= 4'd12) begin
            len = MONTH_LEN[m - 4'd1];
            if (m == 4'd2 && leap_eff) begin
                len = 5'd29;
            end
        end
        return len;
    endfunction

    function automatic logic [3*BCD_W-1:0] dd_step(
        input logic [3*BCD_W-1:0] bcd,
        input logic               bit_in
    );
        logic [3*BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[BCD_W*i +: BCD_W] >= 4'd5) begin
                adj[BCD_W*i +: BCD_W] = adj[BCD_W*i +: BCD_W] + 4'd3;
            end
        end
        return {adj[3*BCD_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential 9-bit double-dabble; the first shift step is folded into load,
// so done pulses 9 cycles after the load edge is sampled.
module bin_to_bcd_seq
    import date_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DOY_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] hund,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic [DOY_W-1:0]   sh_q, sh_d;
    logic [3*BCD_W-1:0] bcd_q, bcd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load) begin
            bcd_d  = dd_step('0, bin[DOY_W-1]);
            sh_d   = {bin[DOY_W-2:0], 1'b0};
            cnt_d  = 4'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = dd_step(bcd_q, sh_q[DOY_W-1]);
            sh_d  = {sh_q[DOY_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hund = bcd_q[3*BCD_W-1:2*BCD_W];
    assign tens = bcd_q[2*BCD_W-1:BCD_W];
    assign ones = bcd_q[BCD_W-1:0];

endmodule

// File: rtl/day_of_year_encoder.sv
// Calendar date to day-of-year (binary + BCD), fixed 22-cycle latency.
// Define LEAP_YEAR_EN to let the leap input lengthen February.
module day_of_year_encoder
    import date_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       month,
    input  logic [3:0]       day_tens,
    input  logic [3:0]       day_ones,
    input  logic             leap,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [DOY_W-1:0] doy,
    output logic [BCD_W-1:0] doy_hund,
    output logic [BCD_W-1:0] doy_tens,
    output logic [BCD_W-1:0] doy_ones
);

    state_e           state_q, state_d;
    date_req_t        req_q, req_d;
    logic [DOY_W-1:0] acc_q, acc_d;
    logic [3:0]       m_q, m_d;
    logic [DOY_W-1:0] doy_q, doy_d;
    logic [BCD_W-1:0] hund_q, hund_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic             err_q, err_d;

    logic             leap_eff;
    logic [6:0]       day;
    logic [4:0]       sel_len;
    logic [4:0]       acc_len;
    logic             date_bad;

    logic             conv_load;
    logic             conv_done;
    logic             unused_conv_busy;
    logic [BCD_W-1:0] conv_hund, conv_tens, conv_ones;

`ifdef LEAP_YEAR_EN
    assign leap_eff = req_q.leap;
`else
    logic unused_leap;
    assign leap_eff    = 1'b0;
    assign unused_leap = ^{leap, req_q.leap};
`endif

    assign day     = 7'(req_q.day_tens) * 7'd10 + 7'(req_q.day_ones);
    assign sel_len = month_len(req_q.month, leap_eff);
    assign acc_len = month_len(m_q, leap_eff);

    // sel_len is zero for an illegal month, which the range test also catches.
    assign date_bad = (req_q.month == 4'd0) || (req_q.month > 4'd12)
                   || (req_q.day_tens > 4'd3) || (req_q.day_ones > 4'd9)
                   || (day == 7'd0) || (day > 7'(sel_len));

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        acc_d     = acc_q;
        m_d       = m_q;
        doy_d     = doy_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        err_d     = err_q;
        conv_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    req_d   = {month, day_tens, day_ones, leap};
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (date_bad) begin
                    err_d   = 1'b1;
                    doy_d   = '0;
                    hund_d  = '0;
                    tens_d  = '0;
                    ones_d  = '0;
                    state_d = S_DONE;
                end else begin
                    acc_d   = DOY_W'(day);
                    m_d     = 4'd1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (m_q < req_q.month) begin
                    acc_d = acc_q + DOY_W'(acc_len);
                end
                m_d = m_q + 4'd1;
                // Converter loads the final sum in the same edge that ends ACCUM.
                if (m_q == 4'd11) begin
                    conv_load = 1'b1;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (conv_done) begin
                    err_d   = 1'b0;
                    doy_d   = acc_q;
                    hund_d  = conv_hund;
                    tens_d  = conv_tens;
                    ones_d  = conv_ones;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            doy_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            doy_q   <= doy_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
        end
    end

    bin_to_bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (conv_load),
        .bin   (acc_d),
        .busy  (unused_conv_busy),
        .done  (conv_done),
        .hund  (conv_hund),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign doy      = doy_q;
    assign doy_hund = hund_q;
    assign doy_tens = tens_q;
    assign doy_ones = ones_q;

endmodule

// File: doc/day_of_year_encoder.md
# day_of_year_encoder

Sequential converter from a calendar date (month, two BCD day digits, leap-year switch) to day-of-year. Output is both 9-bit binary and three BCD digits ready for the 7-segment drivers. It is the inverse of the day-of-year to month/day calculator and sits between the switch/key input logic and the display decoders. A start/busy/done handshake drives it; it walks month lengths one per cycle, then runs a fixed-length binary-to-BCD conversion.

## Interface
Parameters:
- none; all widths and month lengths are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a conversion; sampled only in IDLE.
- month  in  4  binary month, valid range 1..12.
- day_tens  in  4  BCD tens digit of the day of month.
- day_ones  in  4  BCD ones digit of the day of month.
- leap  in  1  1 = leap year (SW[9]).
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse; the result is valid in that cycle and holds afterwards.
- err  out  1  invalid date; updated together with done.
- doy  out  9  binary day-of-year, range 1..366.
- doy_hund, doy_tens, doy_ones  out  4 each  BCD digits of doy.

## Operation
- States are IDLE, VALIDATE, ACCUM, CONVERT and DONE.
- **Capture (IDLE).** If start=1, register month, the day digits and leap, then go to VALIDATE. Inputs are not sampled again until the next accepted start.
- **VALIDATE.**
  - Compute day = day_tens*10 + day_ones as 7 bits.
  - err is set when any of these holds: month=0 or month>12; day_tens>3; day_ones>9; day=0; day > length(month).
  - If err, go directly to DONE with doy and all BCD digits = 0. Otherwise set acc = day and m = 1, then go to ACCUM.
- **ACCUM.** Exactly 11 cycles, m = 1..11.
  - If m < month, acc += length(m).
  - Feb length = 29 when leap is effective, else 28. Month lengths are the standard Jan 31 … Dec 31.
  - acc is 9 bits and cannot overflow, since the maximum is 366.
- **CONVERT.** Exactly 9 cycles of shift-and-add-3 (double-dabble) on acc, producing the hundreds, tens and ones digits.
- **DONE.** For one cycle: done=1; doy, the BCD digits and err are updated from internal registers. Then go to IDLE.
- **Output hold.** Outputs keep their last values in all other states.
- **start while busy.** Ignored; it is neither queued nor an error.
- **Reset mid-operation.** Asynchronous return to IDLE; every output and internal register is cleared.

## Timing
- **Reset values.** busy=0, done=0, err=0, doy=0, all BCD digits=0, state=IDLE.
- **Valid date.** start sampled at edge k:
  - VALIDATE during cycle k+1.
  - ACCUM during k+2..k+12.
  - CONVERT during k+13..k+21.
  - DONE (done=1, outputs valid) during k+22.
  - IDLE at k+23.
  - Latency is a fixed 22 cycles and does not depend on month.
- **Invalid date.** VALIDATE at k+1, DONE with err=1 at k+2.
- **busy.** High throughout VALIDATE through DONE inclusive.
- **Back-to-back start.** The earliest next acceptance is the IDLE cycle after DONE, giving a 23-cycle throughput for valid dates.

## Configuration
- Macro: LEAP_YEAR_EN.
- **Defined:** the leap input selects the February length (28/29). Feb 29 is valid only when leap=1, and dates after February gain +1.
- **Not defined:** the leap input is ignored and February is always 28 days. Feb 29 is flagged err, and the maximum doy is 365.

## Structure
Shared package (date_pkg) contains:
- the state enum;
- the month-length constant array (non-leap);
- the constants 366, the 9-bit doy width and the BCD digit width.

Sub-module bin_to_bcd_seq:
- a 9-bit, 9-cycle sequential double-dabble with load/busy/done;
- instantiated once for CONVERT;
- reusable by the display path.

## Test plan
- **Jan 1.** month=1, day 0/1, leap=0 → done at k+22, doy=1, BCD 0/0/1, err=0.
- **Mar 1.** month=3, day 0/1: leap=0 → doy=60, BCD 0/6/0. leap=1 → doy=61 with LEAP_YEAR_EN defined, 60 with it undefined.
- **Dec 31.** month=12, day 3/1: leap=1 → doy=366, BCD 3/6/6. leap=0 → doy=365.
- **Invalid dates.**
  - Feb 29 with leap=0 → err=1 at k+2, doy=0.
  - Apr 31 → err=1.
  - month=13 → err=1.
  - day_ones=10 → err=1.
- **start while busy.** Pulse start at k+5 with different inputs → ignored; the result matches the first request and one done pulse occurs.
- **Reset mid-operation.** Assert rst_n=0 at k+15 → busy, done, err, doy and all BCD digits are 0 immediately. A new start after release converts Jun 15, leap=0 → doy=166.
